// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size/state encodings and byte-mask helpers
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [7:0] MASK_BYTE  = 8'h01;
    localparam logic [7:0] MASK_HALF  = 8'h03;
    localparam logic [7:0] MASK_WORD  = 8'h0F;
    localparam logic [7:0] MASK_DWORD = 8'hFF;

    function automatic logic [7:0] size_mask(input size_e size);
        case (size)
            SZ_BYTE: return MASK_BYTE;
            SZ_HALF: return MASK_HALF;
            SZ_WORD: return MASK_WORD;
            default: return MASK_DWORD;
        endcase
    endfunction

    // Naturally aligned means the low address bits inside the access size are zero.
    function automatic logic is_misaligned(input size_e size, input logic [2:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane shift, store mask and load extension (shared with fetch path)
module mem_align
    import mem_access_unit_pkg::*;
(
    input  size_e       size,
    input  logic [2:0]  addr_lo,
    input  logic        is_store,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] lane_wdata,
    output logic [7:0]  lane_wmask,
    output logic [63:0] load_data
);

    logic [5:0]  shamt;
    logic [63:0] rshift;
    logic        sext;

    assign shamt      = {addr_lo, 3'b000};
    assign lane_wdata = wdata << shamt;
    assign lane_wmask = is_store ? (size_mask(size) << addr_lo) : 8'h00;
    assign rshift     = rdata >> shamt;
    assign sext       = ~is_unsigned;

    always_comb begin
        load_data = rshift;
        case (size)
            SZ_BYTE: load_data = {{56{sext & rshift[7]}},  rshift[7:0]};
            SZ_HALF: load_data = {{48{sext & rshift[15]}}, rshift[15:0]};
            SZ_WORD: load_data = {{32{sext & rshift[31]}}, rshift[31:0]};
            default: load_data = rshift;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with optional access latency
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_en,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e      state;
    logic [3:0]  cnt;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    size_e       size_q;
    logic        uns_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [63:0] lane_wdata;
    logic [7:0]  lane_wmask;
    logic [63:0] load_data;
    logic        in_access;

    mem_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[2:0]),
        .is_store    (wen_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .lane_wdata  (lane_wdata),
        .lane_wmask  (lane_wmask),
        .load_data   (load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= size_e'(req_size);
                        uns_q   <= req_unsigned;
                        rdata_q <= 64'd0;
                        if (is_misaligned(size_e'(req_size), req_addr[2:0])) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (LATENCY > 0) begin
                            err_q <= 1'b0;
                            cnt   <= WAIT_INIT;
                            state <= ST_WAIT;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    // mem_rdata is only valid during this single strobe cycle.
                    rdata_q <= wen_q ? 64'd0 : load_data;
                    err_q   <= 1'b0;
                    state   <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        rdata_q <= 64'd0;
                        err_q   <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Gating with reset keeps req_ready low while held in reset even though state reads IDLE.
    assign req_ready  = reset && (state == ST_IDLE);
    assign in_access  = (state == ST_ACCESS);
    assign mem_en     = in_access;
    assign mem_addr   = in_access ? {addr_q[63:3], 3'b000} : 64'd0;
    assign mem_wdata  = in_access ? lane_wdata : 64'd0;
    assign mem_wmask  = in_access ? lane_wmask : 8'h00;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit at LATENCY 0 and 3
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    bit          sel;
    logic        req_valid, resp_ready;
    logic        req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_valid0, req_ready0, mem_en0, resp_valid0, resp_ready0, resp_err0;
    logic [63:0] mem_addr0, mem_wdata0, mem_rdata0, resp_rdata0;
    logic [7:0]  mem_wmask0;
    logic        req_valid3, req_ready3, mem_en3, resp_valid3, resp_ready3, resp_err3;
    logic [63:0] mem_addr3, mem_wdata3, mem_rdata3, resp_rdata3;
    logic [7:0]  mem_wmask3;

    logic        req_ready_m, mem_en_m, resp_valid_m, resp_err_m;
    logic [63:0] mem_addr_m, mem_wdata_m, resp_rdata_m;
    logic [7:0]  mem_wmask_m;

    logic [63:0] mem0 [16];
    logic [63:0] mem3 [16];
    logic [63:0] sh0 [16];
    logic [63:0] sh3 [16];
    logic        pl_en, pl_sel;
    logic [3:0]  pl_idx;
    logic [63:0] pl_val;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .mem_en(mem_en0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0), .mem_rdata(mem_rdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    mem_access_unit #(.LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .mem_en(mem_en3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3), .mem_rdata(mem_rdata3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3)
    );

    assign req_valid0  = req_valid & ~sel;
    assign req_valid3  = req_valid & sel;
    assign resp_ready0 = resp_ready & ~sel;
    assign resp_ready3 = resp_ready & sel;

    assign req_ready_m  = sel ? req_ready3  : req_ready0;
    assign mem_en_m     = sel ? mem_en3     : mem_en0;
    assign resp_valid_m = sel ? resp_valid3 : resp_valid0;
    assign resp_err_m   = sel ? resp_err3   : resp_err0;
    assign mem_addr_m   = sel ? mem_addr3   : mem_addr0;
    assign mem_wdata_m  = sel ? mem_wdata3  : mem_wdata0;
    assign mem_wmask_m  = sel ? mem_wmask3  : mem_wmask0;
    assign resp_rdata_m = sel ? resp_rdata3 : resp_rdata0;

    assign mem_rdata0 = mem0[mem_addr0[6:3]];
    assign mem_rdata3 = mem3[mem_addr3[6:3]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: writes the masked lanes on every strobed edge.
    always @(posedge clock) begin
        if (pl_en) begin
            if (pl_sel) mem3[pl_idx] <= pl_val;
            else        mem0[pl_idx] <= pl_val;
        end
        for (int b = 0; b < 8; b++) begin
            if (mem_en0 && mem_wmask0[b]) mem0[mem_addr0[6:3]][8*b +: 8] <= mem_wdata0[8*b +: 8];
            if (mem_en3 && mem_wmask3[b]) mem3[mem_addr3[6:3]][8*b +: 8] <= mem_wdata3[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input bit s, input logic [3:0] idx, input logic [63:0] v);
        pl_sel = s; pl_idx = idx; pl_val = v; pl_en = 1'b1;
        @(posedge clock);
        #1 pl_en = 1'b0;
        if (s) sh3[idx] = v;
        else   sh0[idx] = v;
    endtask

    task automatic shadow_store(input bit s, input logic [63:0] addr, input logic [63:0] wd,
                                input logic [1:0] size);
        int nb = 1 << size;
        for (int i = 0; i < nb; i++) begin
            if (s) sh3[addr[6:3]][8*(addr[2:0]+i) +: 8] = wd[8*i +: 8];
            else   sh0[addr[6:3]][8*(addr[2:0]+i) +: 8] = wd[8*i +: 8];
        end
    endtask

    // Reference: derived from access size in bytes and the byte offset within the dword.
    task automatic ref_model(input bit s, input logic wen, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [1:0] size, input logic uns,
                             output logic [63:0] e_rd, output logic e_err,
                             output logic [63:0] e_wd, output logic [7:0] e_wm, output int e_lat);
        int nb = 1 << size;
        int off = int'(addr % 8);
        logic [63:0] w;
        w     = s ? sh3[addr[6:3]] : sh0[addr[6:3]];
        e_err = (addr % nb) != 0;
        e_lat = e_err ? 1 : (2 + (s ? 3 : 0));
        e_wd  = wd << (8 * off);
        e_wm  = 8'h00;
        e_rd  = 64'd0;
        if (!e_err) begin
            for (int i = 0; i < nb; i++) begin
                if (wen) e_wm[off + i] = 1'b1;
                else     e_rd[8*i +: 8] = w[8*(off+i) +: 8];
            end
            if (!wen && !uns && nb < 8 && e_rd[8*nb-1])
                for (int i = nb; i < 8; i++) e_rd[8*i +: 8] = 8'hFF;
        end
    endtask

    task automatic do_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [1:0] size, input logic uns, input int bp,
                          input logic [63:0] e_rd, input logic e_err,
                          input logic [63:0] e_wd, input logic [7:0] e_wm, input int e_lat);
        int n = 0;
        int j = 0;
        int pulses = 0;
        bit seen = 0;
        bit bus_ok = 1;
        bit hold_ok = 1;
        logic [63:0] rd0;
        logic err0;
        @(negedge clock);
        while (!req_ready_m && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_before_accept", req_ready_m, 1);
        req_wen = wen; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (!seen && j < 40) begin
            @(negedge clock);
            j++;
            if (mem_en_m) begin
                pulses++;
                chk("mem_addr", mem_addr_m, {addr[63:3], 3'b000});
                chk("mem_wmask", mem_wmask_m, e_wm);
                if (wen) chk("mem_wdata", mem_wdata_m, e_wd);
            end else if ((mem_addr_m | mem_wdata_m | {56'd0, mem_wmask_m}) != 64'd0) begin
                bus_ok = 0;
            end
            if (resp_valid_m) seen = 1;
        end
        chk("resp_latency", seen ? j : 999, e_lat);
        chk("bus_zero_outside_access", bus_ok, 1);
        chk("resp_rdata", resp_rdata_m, e_rd);
        chk("resp_err", resp_err_m, e_err);
        rd0 = resp_rdata_m; err0 = resp_err_m;
        for (int k = 0; k < bp; k++) begin
            @(negedge clock);
            if (!resp_valid_m || resp_rdata_m !== rd0 || resp_err_m !== err0 || mem_en_m || req_ready_m)
                hold_ok = 0;
            if (mem_en_m) pulses++;
        end
        if (bp > 0) chk("backpressure_hold", hold_ok, 1);
        chk("mem_en_pulses", pulses, e_err ? 0 : 1);
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        chk("resp_valid_after_handshake", resp_valid_m, 0);
        chk("req_ready_after_handshake", req_ready_m, 1);
    endtask

    typedef struct {
        bit          s;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] pre;
        int          bp;
        logic [63:0] e_rd;
        logic        e_err;
        logic [63:0] e_wd;
        logic [7:0]  e_wm;
        int          e_lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [63:0] e_rd, e_wd, a, w;
        logic        e_err;
        logic [7:0]  e_wm;
        int          e_lat, pulses;
        logic        rw, ru;
        logic [1:0]  rs;

        tbl[0] = '{0, 0, 64'h80000004, 64'h0, 2, 0, 64'h8000000112345678, 0,
                   64'hFFFFFFFF80000001, 0, 64'h0, 8'h00, 2};
        tbl[1] = '{0, 1, 64'h80000006, 64'hBEEF, 1, 0, 64'h0, 0,
                   64'h0, 0, 64'hBEEF000000000000, 8'hC0, 2};
        tbl[2] = '{0, 0, 64'h80000002, 64'h0, 2, 0, 64'h0, 0,
                   64'h0, 1, 64'h0, 8'h00, 1};
        tbl[3] = '{1, 0, 64'h80000007, 64'h0, 0, 1, 64'h9A00000000000011, 0,
                   64'h9A, 0, 64'h0, 8'h00, 5};
        tbl[4] = '{0, 0, 64'h80000008, 64'h0, 3, 0, 64'h0123456789ABCDEF, 10,
                   64'h0123456789ABCDEF, 0, 64'h0, 8'h00, 2};
        tbl[5] = '{1, 0, 64'h80000012, 64'h0, 1, 0, 64'h0000000080010000, 0,
                   64'hFFFFFFFFFFFF8001, 0, 64'h0, 8'h00, 5};
        tbl[6] = '{0, 1, 64'h80000003, 64'h55, 0, 0, 64'h0, 0,
                   64'h0, 0, 64'h0000000055000000, 8'h08, 2};
        tbl[7] = '{1, 1, 64'h80000004, 64'h1122334455667788, 3, 0, 64'h0, 3,
                   64'h0, 1, 64'h0, 8'h00, 1};
        tbl[8] = '{1, 0, 64'h80000017, 64'h0, 0, 0, 64'h9A00000000000000, 0,
                   64'hFFFFFFFFFFFFFF9A, 0, 64'h0, 8'h00, 5};

        reset = 1'b0; sel = 0; req_valid = 0; resp_ready = 0;
        req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        pl_en = 0; pl_sel = 0; pl_idx = 0; pl_val = 0;
        #7;
        chk("rst_ctrl0", {req_ready0, mem_en0, resp_valid0, resp_err0}, 0);
        chk("rst_bus0", mem_addr0 | mem_wdata0 | resp_rdata0 | {56'd0, mem_wmask0}, 0);
        chk("rst_ctrl3", {req_ready3, mem_en3, resp_valid3, resp_err3}, 0);
        chk("rst_bus3", mem_addr3 | mem_wdata3 | resp_rdata3 | {56'd0, mem_wmask3}, 0);
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                preload(s[0], 4'(i), {$urandom, $urandom});
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("post_reset_ready0", req_ready0, 1);
        chk("post_reset_ready3", req_ready3, 1);

        for (int i = 0; i < 9; i++) begin
            sel = tbl[i].s;
            if (!tbl[i].wen) preload(tbl[i].s, tbl[i].addr[6:3], tbl[i].pre);
            do_txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, tbl[i].bp,
                   tbl[i].e_rd, tbl[i].e_err, tbl[i].e_wd, tbl[i].e_wm, tbl[i].e_lat);
            if (tbl[i].wen && !tbl[i].e_err)
                shadow_store(tbl[i].s, tbl[i].addr, tbl[i].wdata, tbl[i].size);
        end

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 1);
            a  = 64'h80000000 + 64'($urandom_range(0, 127));
            w  = {$urandom, $urandom};
            rw = $urandom_range(0, 1);
            rs = 2'($urandom_range(0, 3));
            ru = $urandom_range(0, 1);
            ref_model(sel, rw, a, w, rs, ru, e_rd, e_err, e_wd, e_wm, e_lat);
            do_txn(rw, a, w, rs, ru, $urandom_range(0, 3), e_rd, e_err, e_wd, e_wm, e_lat);
            if (rw && !e_err) shadow_store(sel, a, w, rs);
        end

        // Reset asserted while the LATENCY=3 unit sits in WAIT.
        sel = 1;
        @(negedge clock);
        req_wen = 0; req_addr = 64'h80000020; req_size = 2; req_unsigned = 0; req_valid = 1;
        @(posedge clock);
        #1 req_valid = 0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midwait_rst_ctrl", {req_ready3, mem_en3, resp_valid3, resp_err3}, 0);
        chk("midwait_rst_bus", mem_addr3 | mem_wdata3 | resp_rdata3 | {56'd0, mem_wmask3}, 0);
        pulses = 0;
        repeat (2) begin
            @(negedge clock);
            if (mem_en3) pulses++;
        end
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("midwait_release_ready", req_ready3, 1);
        repeat (10) begin
            @(negedge clock);
            if (mem_en3 || resp_valid3) pulses++;
        end
        chk("midwait_no_late_access", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL provide parameter LATENCY, default 0, meaning extra wait cycles (0..15) between request accept and memory access.
REQ-002 SHALL provide port clock, in, 1, single clock, rising edge.
REQ-003 SHALL provide port reset, in, 1, asynchronous active-low reset.
REQ-004 SHALL provide port req_valid, in, 1, request present.
REQ-005 SHALL provide port req_ready, out, 1, unit can accept a request.
REQ-006 SHALL provide port req_wen, in, 1, 1 = store, 0 = load.
REQ-007 SHALL provide port req_addr, in, 64, byte address.
REQ-008 SHALL provide port req_wdata, in, 64, store data, right-aligned.
REQ-009 SHALL provide port req_size, in, 2, 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 SHALL provide port req_unsigned, in, 1, zero-extend loads when 1.
REQ-011 SHALL provide port mem_en, out, 1, memory strobe to the memory model.
REQ-012 SHALL provide port mem_addr, out, 64, 8-byte-aligned address.
REQ-013 SHALL provide ports mem_wdata (out, 64) and mem_wmask (out, 8), lane-shifted store data and byte mask.
REQ-014 SHALL provide port mem_rdata, in, 64, combinational read data valid while mem_en = 1.
REQ-015 SHALL provide ports resp_valid (out, 1), resp_ready (in, 1), resp_rdata (out, 64) and resp_err (out, 1, misaligned access).

Function
REQ-016 SHALL implement states IDLE, WAIT, ACCESS and RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; on req_valid && req_ready, SHALL register all req_* fields.
REQ-018 SHALL flag misalignment for half with addr[0] = 1, word with addr[1:0] != 0, and dword with addr[2:0] != 0.
REQ-019 On a misaligned accept, SHALL go to RESP with resp_err = 1 and resp_rdata = 0, and SHALL never assert mem_en.
REQ-020 On an aligned accept, SHALL go to WAIT with counter = LATENCY-1 when LATENCY > 0, otherwise directly to ACCESS.
REQ-021 In WAIT, SHALL decrement the counter each cycle and go to ACCESS on the cycle after the counter reaches 0.
REQ-022 In ACCESS, SHALL hold mem_en = 1 for exactly one cycle per accepted aligned request, then go to RESP; the memory model performs its write on every evaluation, so this one-cycle pulse is mandatory.
REQ-023 SHALL drive mem_addr = {addr[63:3],000}; mem_wdata = wdata << (8*addr[2:0]); and mem_wmask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0] for stores, 0x00 for loads.
REQ-024 SHALL drive mem_addr, mem_wdata and mem_wmask to 0 outside ACCESS.
REQ-025 For loads, SHALL capture mem_rdata at the end of ACCESS, shift it right by 8*addr[2:0], truncate it to size, and sign-extend it unless req_unsigned = 1; dword loads SHALL pass unchanged.
REQ-026 For stores, SHALL set resp_rdata = 0 and resp_err = 0.
REQ-027 In RESP, SHALL hold resp_valid = 1 with stable resp_rdata and resp_err until resp_ready = 1, then return to IDLE.
REQ-028 SHALL make resp_ready = 0 back-pressure indefinitely without re-issuing mem_en.
REQ-029 SHALL have a latency from accept cycle N to resp_valid of N+2+LATENCY for aligned accesses and N+1 for misaligned ones.
REQ-030 SHALL NOT combinationally couple req_ready to resp_ready; the next request is accepted no earlier than the cycle after the response handshake.

Reset
REQ-031 While reset = 0, SHALL force state IDLE, counter 0, and all registered fields 0.
REQ-032 During reset, SHALL drive outputs req_ready = 0, mem_en = 0, resp_valid = 0, resp_err = 0, and mem_addr, mem_wdata, mem_wmask and resp_rdata to 0.
REQ-033 SHALL drop an outstanding request on reset assertion mid-operation, with no mem_en afterwards.
REQ-034 SHALL drive req_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-035 SHALL place the size encodings, state encoding and mask constants in a shared package.
REQ-036 SHALL place the combinational lane shift, mask and extend logic in sub-module mem_align, reused by the fetch path.

Verification
REQ-037 SHALL cover: LATENCY = 0, load word, addr 0x80000004, mem_rdata 0x8000_0001_xxxx_xxxx -> mem_en one cycle at mem_addr 0x80000000, resp_rdata 0xFFFF_FFFF_8000_0001 two cycles after accept.
REQ-038 SHALL cover: store half 0xBEEF, addr 0x80000006 -> mem_wdata 0xBEEF_0000_0000_0000, mem_wmask 0xC0, resp_rdata 0.
REQ-039 SHALL cover: load word, addr 0x80000002 -> resp_err = 1 one cycle after accept, mem_en never asserted.
REQ-040 SHALL cover: LATENCY = 3, load byte unsigned, addr 0x80000007, rdata[63:56] = 0x9A -> resp_valid five cycles after accept, resp_rdata 0x9A.
REQ-041 SHALL cover: resp_ready held 0 for 10 cycles -> resp_valid and resp_rdata stable, exactly one mem_en pulse, req_ready = 0 throughout.
REQ-042 SHALL cover: reset asserted in WAIT -> all outputs 0 immediately, no later mem_en, req_ready = 1 in the first cycle after release.
